cla_pipe_adder: RTL

Parametrised, pipelined carry-lookahead adder/subtractor with a valid/ready stream interface. It generalises the fixed 16-bit combinational adder used in the approximate-multiplier datapaths to arbitrary width, lookahead block size, pipeline depth and add/sub mode. It is intended as the final accumulation adder behind partial-product compressors, where timing closure needs the carry chain cut into registered segments.

---
 rtl/cla_pkg.sv | 22 ++
 rtl/cla_block.sv | 41 ++++
 rtl/cla_pipe_adder.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared types and elaboration helpers for the pipelined CLA adder
package cla_pkg;

  typedef struct packed {
    logic p;
    logic g;
  } grp_pg_t;

  function automatic int nblk(input int width, input int block);
    return width / block;
  endfunction

  function automatic int grp_per_stage(input int width, input int block, input int stages);
    return (width / block) / stages;
  endfunction

  function automatic bit params_ok(input int width, input int block, input int stages);
    return (block > 0) && (stages >= 1) && (width % block == 0) &&
           ((width / block) % stages == 0);
  endfunction

endpackage

// File: rtl/cla_block.sv
// rtl/cla_block.sv - one BLOCK-bit carry-lookahead group, purely combinational
module cla_block
  import cla_pkg::*;
#(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] p,
  input  logic [BLOCK-1:0] g,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output grp_pg_t          grp,
  output logic             cout
);

  logic [BLOCK:0] c;
  logic           acc;
  logic           run;

  // Each carry is expanded as a flat sum of generate terms, so no bit waits on its neighbour.
  always_comb begin
    c    = '0;
    c[0] = cin;
    acc  = 1'b0;
    run  = 1'b1;
    for (int i = 0; i < BLOCK; i++) begin
      acc = 1'b0;
      run = 1'b1;
      for (int j = i; j >= 0; j--) begin
        acc = acc | (g[j] & run);
        run = run & p[j];
      end
      c[i+1] = acc | (run & cin);
    end
    grp.g = acc;
    grp.p = run;
  end

  assign sum  = p ^ c[BLOCK-1:0];
  assign cout = c[BLOCK];

endmodule

// File: rtl/cla_pipe_adder.sv
// rtl/cla_pipe_adder.sv - pipelined carry-lookahead adder/subtractor with valid/ready stream
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int BLOCK  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  input  logic             sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH:0]   sum,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int NBLK = nblk(WIDTH, BLOCK);
  localparam int GPS  = grp_per_stage(WIDTH, BLOCK, STAGES);
  localparam int SW   = GPS * BLOCK;

  if (!params_ok(WIDTH, BLOCK, STAGES)) begin : g_bad_params
    $error("cla_pipe_adder: illegal WIDTH/BLOCK/STAGES combination");
  end

  logic             en;
  logic [WIDTH-1:0] a_in [STAGES];
  logic [WIDTH-1:0] b_in [STAGES];
  logic [WIDTH-1:0] s_in [STAGES];
  logic [WIDTH-1:0] p_in [STAGES];
  logic [WIDTH-1:0] g_in [STAGES];
  logic             c_in [STAGES];
  logic             v_in [STAGES];

  logic [WIDTH-1:0] a_q [STAGES], a_d [STAGES];
  logic [WIDTH-1:0] b_q [STAGES], b_d [STAGES];
  logic [WIDTH-1:0] s_q [STAGES], s_d [STAGES];
  logic             c_q [STAGES], c_d [STAGES];
  logic             v_q [STAGES], v_d [STAGES];
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0]  blk_sum;
  logic [STAGES-1:0] stg_cout;
  // Group P/G is there for a second lookahead level; within a stage the groups ripple on cout.
  grp_pg_t [NBLK-1:0] grp_pg_unused;

  assign en        = !v_q[STAGES-1] || out_ready;
  assign in_ready  = en;
  assign out_valid = v_q[STAGES-1];
  assign sum       = {c_q[STAGES-1], s_q[STAGES-1]};
  assign ovf       = ovf_q;

  always_comb begin
    a_in[0] = in1;
    b_in[0] = sub ? ~in2 : in2;
    s_in[0] = '0;
    c_in[0] = sub | cin;
    v_in[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_in[k] = a_q[k-1];
      b_in[k] = b_q[k-1];
      s_in[k] = s_q[k-1];
      c_in[k] = c_q[k-1];
      v_in[k] = v_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      p_in[k] = a_in[k] ^ b_in[k];
      g_in[k] = a_in[k] & b_in[k];
    end
  end

  for (genvar j = 0; j < NBLK; j++) begin : g_grp
    localparam int K = j / GPS;
    logic ci;
    logic co;
    if (j % GPS == 0) begin : g_first
      assign ci = c_in[K];
    end else begin : g_chain
      assign ci = g_grp[j-1].co;
    end
    cla_block #(.BLOCK(BLOCK)) u_blk (
      .p    (p_in[K][j*BLOCK +: BLOCK]),
      .g    (g_in[K][j*BLOCK +: BLOCK]),
      .cin  (ci),
      .sum  (blk_sum[j*BLOCK +: BLOCK]),
      .grp  (grp_pg_unused[j]),
      .cout (co)
    );
    if (j % GPS == GPS - 1) begin : g_last
      assign stg_cout[K] = co;
    end
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      a_d[k] = a_q[k];
      b_d[k] = b_q[k];
      s_d[k] = s_q[k];
      c_d[k] = c_q[k];
      v_d[k] = v_q[k];
    end
    ovf_d = ovf_q;
    if (en) begin
      for (int k = 0; k < STAGES; k++) begin
        v_d[k]              = v_in[k];
        a_d[k]              = a_in[k];
        b_d[k]              = b_in[k];
        s_d[k]              = s_in[k];
        s_d[k][k*SW +: SW]  = blk_sum[k*SW +: SW];
        c_d[k]              = stg_cout[k];
      end
      // Carry into the MSB is recovered from its sum bit, since sum = p ^ c.
      ovf_d = stg_cout[STAGES-1] ^ blk_sum[WIDTH-1] ^ p_in[STAGES-1][WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
        c_q[k] <= c_d[k];
        v_q[k] <= v_d[k];
      end
      ovf_q <= ovf_d;
    end
  end

endmodule
